// File: rtl/clk_rst_pkg.sv
// Shared clock/reset definitions: reset sequencer state encoding and timer sizing.
package clk_rst_pkg;

    typedef enum logic [2:0] {
        PLLRST,
        WAITLOCK,
        FILTER,
        RELEASE,
        RUN
    } seq_state_t;

    // Width that holds the largest of the given counts, with one bit of headroom.
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m < 1) m = 1;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parametrised-width two-flop synchroniser with synchronous active-low reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_p0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_p0 <= '0;
            q        <= '0;
        end else begin
            stage_p0 <= d;
            q        <= stage_p0;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor and staggered domain reset sequencer on the free-running reference clock.
// Define PLL_RESET_SEQUENCER_STATS_EN to add the saturating lock_loss_cnt output.
module pll_reset_sequencer
    import clk_rst_pkg::*;
#(
    parameter int NUM_RST        = 4,
    parameter int LOCK_FILTER    = 1024,
    parameter int STAGGER        = 16,
    parameter int RELOCK_TIMEOUT = 65536,
    parameter int PLL_RST_CYCLES = 8,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked,
    output logic               pll_rst,
    input  logic               sw_rst_req,
    output logic [NUM_RST-1:0] rst_n_out,
    output logic               all_ready
`ifdef PLL_RESET_SEQUENCER_STATS_EN
    ,
    output logic [CNT_W-1:0]   lock_loss_cnt
`endif
);

    localparam int TIMER_W = timer_width(RELOCK_TIMEOUT, LOCK_FILTER, PLL_RST_CYCLES,
                                         (NUM_RST - 1) * STAGGER);

    if (NUM_RST < 1 || NUM_RST > 16 || STAGGER < 1 || PLL_RST_CYCLES < 1 ||
        LOCK_FILTER < 1 || RELOCK_TIMEOUT < 1 || CNT_W < 1) begin : g_bad_params
        $error("pll_reset_sequencer: parameter out of range");
    end

    seq_state_t         state;
    logic [TIMER_W-1:0] timer;
    logic               lock_s;
    logic               live;
    logic               lock_lost;
    logic               sw_hit;
    logic [NUM_RST-1:0] rel_mask;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    assign live      = (state == RELEASE) || (state == RUN);
    assign lock_lost = live && !lock_s;
    assign sw_hit    = live && lock_s && sw_rst_req;

    // Outputs due once the timer advances: bit i is released when the timer reaches i*STAGGER.
    always_comb begin
        rel_mask = '0;
        for (int i = 0; i < NUM_RST; i++) begin
            if (int'(timer) + 1 >= i * STAGGER) rel_mask[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= PLLRST;
            timer     <= '0;
            pll_rst   <= 1'b1;
            rst_n_out <= '0;
            all_ready <= 1'b0;
        end else begin
            timer <= timer + TIMER_W'(1);
            if (lock_lost) begin
                state     <= WAITLOCK;
                timer     <= '0;
                rst_n_out <= '0;
                all_ready <= 1'b0;
            end else if (sw_hit) begin
                // PLL is still good, so only the lock filter is re-run.
                state     <= FILTER;
                timer     <= '0;
                rst_n_out <= '0;
                all_ready <= 1'b0;
            end else begin
                case (state)
                    PLLRST: begin
                        if (timer == TIMER_W'(PLL_RST_CYCLES - 1)) begin
                            state   <= WAITLOCK;
                            timer   <= '0;
                            pll_rst <= 1'b0;
                        end
                    end
                    WAITLOCK: begin
                        if (lock_s) begin
                            state <= FILTER;
                            timer <= '0;
                        end else if (timer == TIMER_W'(RELOCK_TIMEOUT - 1)) begin
                            state   <= PLLRST;
                            timer   <= '0;
                            pll_rst <= 1'b1;
                        end
                    end
                    FILTER: begin
                        if (!lock_s) begin
                            state <= WAITLOCK;
                            timer <= '0;
                        end else if (timer == TIMER_W'(LOCK_FILTER - 1)) begin
                            state     <= RELEASE;
                            timer     <= '0;
                            rst_n_out <= NUM_RST'(1);
                        end
                    end
                    RELEASE: begin
                        if (rst_n_out[NUM_RST-1]) begin
                            state     <= RUN;
                            timer     <= '0;
                            all_ready <= 1'b1;
                        end else begin
                            rst_n_out <= rel_mask;
                        end
                    end
                    RUN: begin
                        timer <= '0;
                    end
                    default: begin
                        state     <= PLLRST;
                        timer     <= '0;
                        pll_rst   <= 1'b1;
                        rst_n_out <= '0;
                        all_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PLL_RESET_SEQUENCER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_loss_cnt <= '0;
        end else if (lock_lost && (lock_loss_cnt != {CNT_W{1'b1}})) begin
            lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
